// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: wishbone read master that streams a linear SDRAM region
// into a local first-word-fall-through FIFO. One outstanding single-word read
// at a time, gated by FIFO space, with retry back-off and abort handling.
module sdram_burst_reader #(
  parameter int ADR_WIDTH = 25,
  parameter int LEN_WIDTH = 16,
  parameter int FIFO_AW   = 4,
  parameter int RETRY_MAX = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADR_WIDTH-1:0] base_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [3:0]           sel_o,
  output logic                 we_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  input  logic [31:0]          dat_i,
  input  logic                 ack_i,
  input  logic                 err_i,
  input  logic                 rty_i,
  output logic [31:0]          q_dat_o,
  output logic                 q_valid_o,
  input  logic                 q_ready_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  // Retry counter must be able to hold RETRY_MAX+1 without wrapping.
  localparam int RW    = $clog2(RETRY_MAX + 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_BACKOFF} state_t;

  state_t               state, state_n;

  logic [ADR_WIDTH-1:0] adr_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [RW-1:0]        rty_q;
  logic                 bo_q, bo_n;       // second back-off cycle marker
  logic                 abort_q, abort_n; // abort seen while a read is in flight

  logic                 start_acc;
  logic                 done_n;
  logic                 err_set;
  logic                 word_ok;
  logic                 rty_inc;
  logic                 rty_clr;

  logic [31:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wp, rp;
  logic [FIFO_AW:0]     cnt;
  logic                 push, pop, space_ok;

  // Address bits [1:0] are dropped: every access is a full aligned word.
  logic                 unused_base;
  assign unused_base = ^base_i[1:0];

  assign push     = word_ok;
  assign pop      = (cnt != '0) && q_ready_i;
  // A pop in this cycle frees a slot even when the FIFO currently reads full.
  assign space_ok = (cnt < (FIFO_AW+1)'(DEPTH)) || pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    done_n    = 1'b0;
    err_set   = 1'b0;
    word_ok   = 1'b0;
    rty_inc   = 1'b0;
    rty_clr   = 1'b0;
    bo_n      = bo_q;
    abort_n   = abort_q;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          rty_clr   = 1'b1;
          abort_n   = 1'b0;
          if (len_i == '0) done_n  = 1'b1;
          else             state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (space_ok) begin
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        // An abort cannot cut a bus cycle short; remember it for the response.
        if (abort_i) abort_n = 1'b1;
        if (err_i) begin
          err_set = 1'b1;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (rty_i) begin
          if (abort_i || abort_q) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else if (rty_q >= RW'(RETRY_MAX)) begin
            err_set = 1'b1;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            rty_inc = 1'b1;
            bo_n    = 1'b0;
            state_n = S_BACKOFF;
          end
        end else if (ack_i) begin
          word_ok = 1'b1;
          rty_clr = 1'b1;
          if (rem_q == LEN_WIDTH'(1) || abort_i || abort_q) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            // Via WAIT so cyc/stb drop for at least one cycle between reads.
            state_n = S_WAIT;
          end
        end
      end
      S_BACKOFF: begin
        if (abort_i) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (bo_q) begin
          state_n = S_REQ;
        end else begin
          bo_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: address, remaining words, retries, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q   <= '0;
      rem_q   <= '0;
      rty_q   <= '0;
      bo_q    <= 1'b0;
      abort_q <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o  <= done_n;
      bo_q    <= bo_n;
      abort_q <= abort_n;
      if (start_acc) begin
        adr_q <= {base_i[ADR_WIDTH-1:2], 2'b00};
        rem_q <= len_i;
      end else if (word_ok) begin
        adr_q <= adr_q + ADR_WIDTH'(4);
        rem_q <= rem_q - LEN_WIDTH'(1);
      end
      if (rty_clr)      rty_q <= '0;
      else if (rty_inc) rty_q <= rty_q + RW'(1);
      if (start_acc)    err_o <= 1'b0;
      else if (err_set) err_o <= 1'b1;
    end
  end

  // FIFO storage; written only on an accepted ack
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= dat_i;
  end

  // FIFO pointers and occupancy; a new transfer flushes stale data
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + FIFO_AW'(1);
      if (pop)  rp <= rp + FIFO_AW'(1);
      if (push && !pop)      cnt <= cnt + (FIFO_AW+1)'(1);
      else if (!push && pop) cnt <= cnt - (FIFO_AW+1)'(1);
    end
  end

  assign busy_o    = (state != S_IDLE);
  assign cyc_o     = (state == S_REQ);
  assign stb_o     = cyc_o;
  assign sel_o     = stb_o ? 4'hF : 4'h0;
  assign we_o      = 1'b0;
  assign adr_o     = adr_q;
  assign q_valid_o = (cnt != '0);
  assign q_dat_o   = q_valid_o ? mem[rp] : 32'h0;

endmodule

// File: tb/tb_sdram_burst_reader.sv
// tb_sdram_burst_reader: randomized and directed checks of the burst reader
// against a word-list model (expected addresses/data derived from base, length
// and the injected slave responses).
module tb_sdram_burst_reader;
  localparam int AW = 25, LW = 16, DEPTH = 16, RMAX = 7;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start_i = 1'b0, abort_i = 1'b0;
  logic [AW-1:0] base_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, err_o, we_o, cyc_o, stb_o;
  logic [AW-1:0] adr_o;
  logic [3:0]    sel_o;
  logic [31:0]   dat_i = '0;
  logic          ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic [31:0]   q_dat_o;
  logic          q_valid_o;
  logic          q_ready_i = 1'b0;

  sdram_burst_reader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .base_i(base_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .adr_o(adr_o), .sel_o(sel_o), .we_o(we_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i),
    .err_i(err_i), .rty_i(rty_i), .q_dat_o(q_dat_o), .q_valid_o(q_valid_o),
    .q_ready_i(q_ready_i)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    return ({7'h0, a} * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // scenario configuration, written by the main process only
  logic [AW-1:0] cur_base = '0;
  int cur_dly = 0, rand_dly = 0, rty_w = -1, rty_n = 0, err_w = -1, abort_w = -1;
  int rmode = 0, xfer_id = 0, abort_reqs = 0;

  // logs, written by the monitor processes only
  logic [AW-1:0] ack_adr[$], rty_adr[$];
  logic [31:0]   popped[$];
  int            gaps[$];
  int            done_cnt = 0, viol = 0;

  // snapshots taken at each start
  int ack0, rty0, pop0, gap0, done0;

  // slave state
  int sl_id = 0, rty_seen = 0, after_rty = 0, lim = 0, wcnt = 0, idle_run = 0, idx;
  logic sl_prev = 1'b0;
  logic [AW-1:0] diff;

  // Wishbone slave: responds after a configurable wait, injects rty/err by word index
  always @(negedge clk) begin
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    if (xfer_id != sl_id) begin
      sl_id = xfer_id; rty_seen = 0; after_rty = 0; wcnt = 0;
      lim = (rand_dly != 0) ? int'($urandom_range(0, 2)) : cur_dly;
    end
    if (cyc_o) begin
      if (!sl_prev && after_rty != 0) begin gaps.push_back(idle_run); after_rty = 0; end
      idle_run = 0;
    end else idle_run++;
    sl_prev = cyc_o;
    if (cyc_o && stb_o) begin
      if (wcnt < lim) wcnt++;
      else begin
        wcnt = 0;
        diff = adr_o - cur_base;
        idx = int'(diff >> 2);
        if (idx == err_w) err_i = 1'b1;
        else if (idx == rty_w && rty_seen < rty_n) begin
          rty_i = 1'b1; rty_seen++; rty_adr.push_back(adr_o); after_rty = 1;
        end else begin
          ack_i = 1'b1; dat_i = data_of(adr_o); ack_adr.push_back(adr_o);
        end
        lim = (rand_dly != 0) ? int'($urandom_range(0, 2)) : cur_dly;
      end
    end else wcnt = 0;
  end

  // Consumer: choose ready for the coming edge, log the word it pops
  always @(negedge clk) begin
    case (rmode)
      0: q_ready_i = 1'b0;
      1: q_ready_i = 1'b1;
      default: q_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (q_valid_o && q_ready_i) popped.push_back(q_dat_o);
  end

  // Protocol monitor
  always @(negedge clk) begin
    if (done_o) begin done_cnt++; if (busy_o) viol++; end
    if (stb_o && !cyc_o) viol++;
    if (sel_o !== (stb_o ? 4'hF : 4'h0)) viol++;
    if (we_o !== 1'b0) viol++;
  end

  // Abort driver: on the Nth bus cycle of a transfer, or on request
  int ab_id = 0, rises = 0, ab_seen = 0;
  logic ab_prev = 1'b0;
  always @(negedge clk) begin
    abort_i = 1'b0;
    if (xfer_id != ab_id) begin ab_id = xfer_id; rises = 0; end
    if (cyc_o && !ab_prev) begin
      rises++;
      if (abort_w >= 0 && rises == abort_w + 1) abort_i = 1'b1;
    end
    ab_prev = cyc_o;
    if (abort_reqs != ab_seen) begin ab_seen++; abort_i = 1'b1; end
  end

  task automatic start_xfer(input logic [AW-1:0] base, input int len);
    @(negedge clk);
    cur_base = {base[AW-1:2], 2'b00};
    xfer_id++;
    ack0 = ack_adr.size(); rty0 = rty_adr.size(); pop0 = popped.size();
    gap0 = gaps.size(); done0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; base_i = base; len_i = LW'(len);
    @(negedge clk);
    start_i = 1'b0;
    check("err_clr", err_o, 0);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == done0 && n < bound) begin @(negedge clk); n++; end
    check("timeout", n >= bound, 0);
  endtask

  task automatic finish_check(input int exp_n, input int exp_err, input int rm);
    logic [AW-1:0] expa;
    repeat (2) @(negedge clk);
    check("err", err_o, exp_err);
    check("busy_end", busy_o, 0);
    check("cyc_end", cyc_o, 0);
    if (rm == 0 && exp_n > 0) check("q_kept", q_valid_o, 1);
    rmode = 1;
    repeat (DEPTH + 4) @(negedge clk);
    check("done_cnt", done_cnt - done0, 1);
    check("n_acks", ack_adr.size() - ack0, exp_n);
    check("n_pops", popped.size() - pop0, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      expa = cur_base + AW'(4 * i);
      if (ack0 + i < ack_adr.size()) check("adr", ack_adr[ack0 + i], expa);
      if (pop0 + i < popped.size())  check("dat", popped[pop0 + i], data_of(expa));
    end
    check("q_empty", q_valid_o, 0);
    check("protocol", viol, 0);
  endtask

  task automatic run_xfer(input logic [AW-1:0] base, input int len, input int rm, input int dly,
                          input int rw, input int rn, input int ew, input int aw);
    int n, e, reach, exp_r;
    logic [AW-1:0] ra;
    rmode = rm; rand_dly = (dly < 0) ? 1 : 0; cur_dly = (dly < 0) ? 0 : dly;
    rty_w = rw; rty_n = rn; err_w = ew; abort_w = aw;
    start_xfer(base, len);
    wait_done(3000);
    n = len; e = 0;
    if (ew >= 0 && ew < n) begin n = ew; e = 1; end
    if (rn > RMAX && rw >= 0 && rw < n) begin n = rw; e = 1; end
    if (aw >= 0 && aw + 1 < n) n = aw + 1;
    finish_check(n, e, rm);
    reach = (rn > 0 && rw >= 0 && rw < len && !(ew >= 0 && ew <= rw)) ? 1 : 0;
    if (reach != 0) begin
      exp_r = (rn > RMAX) ? RMAX + 1 : rn;
      ra = cur_base + AW'(4 * rw);
      check("n_rty", rty_adr.size() - rty0, exp_r);
      for (int i = rty0; i < rty_adr.size(); i++) check("rty_adr", rty_adr[i], ra);
      check("n_gaps", gaps.size() - gap0, (rn > RMAX) ? RMAX : rn);
      for (int i = gap0; i < gaps.size(); i++) check("rty_gap", gaps[i], 2);
    end
  endtask

  initial begin
    logic [31:0] r;
    int len, kind, rw, rn, ew;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy_o, done_o, err_o, cyc_o, stb_o, we_o, sel_o, adr_o, q_valid_o, q_dat_o}, 0);
    rst = 1'b0;

    // basic 4-word read
    run_xfer(25'h100, 4, 1, 1, -1, 0, -1, -1);

    // FIFO back-pressure: 16 reads then stall
    rmode = 0; rand_dly = 0; cur_dly = 0; rty_w = -1; rty_n = 0; err_w = -1; abort_w = -1;
    start_xfer(25'h2000, 20);
    repeat (150) @(negedge clk);
    check("stall_acks", ack_adr.size() - ack0, 16);
    check("stall_busy", busy_o, 1);
    check("stall_cyc", cyc_o, 0);
    rmode = 1;
    wait_done(500);
    finish_check(20, 0, 1);

    // stall, then abort while waiting for space
    rmode = 0;
    start_xfer(25'h3000, 20);
    repeat (150) @(negedge clk);
    abort_reqs++;
    wait_done(50);
    finish_check(16, 0, 0);

    // retries: word 2 twice, then RETRY_MAX+1 on word 1
    run_xfer(25'h500, 4, 1, 1, 2, 2, -1, -1);
    run_xfer(25'h600, 4, 1, 0, 1, 8, -1, -1);

    // zero-length start clears the sticky error and finishes at once
    @(negedge clk);
    xfer_id++; done0 = done_cnt;
    start_i = 1'b1; len_i = '0; base_i = 25'h40;
    @(negedge clk);
    start_i = 1'b0;
    check("len0_done", done_o, 1);
    check("len0_busy", busy_o, 0);
    check("len0_err", err_o, 0);
    @(negedge clk);
    check("len0_pulse", done_o, 0);

    // bus error on word 3 of 5, consumer stalled
    run_xfer(25'h700, 5, 0, 1, -1, 0, 2, -1);
    // address wrap
    run_xfer(25'h1FFFFFC, 2, 1, 0, -1, 0, -1, -1);
    // abort during a slow bus cycle keeps the word
    run_xfer(25'h400, 6, 1, 3, -1, 0, -1, 2);

    for (int t = 0; t < 12; t++) begin
      r = $urandom;
      len = int'($urandom_range(1, 24));
      kind = int'($urandom_range(0, 2));
      rw = -1; rn = 0; ew = -1;
      if (kind == 1) begin
        rw = int'($urandom_range(0, len - 1));
        rn = ($urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(1, 3));
      end
      if (kind == 2) ew = int'($urandom_range(0, len - 1));
      run_xfer(r[AW-1:0], len, 2, -1, rw, rn, ew, -1);
    end

    // reset in the middle of a transfer
    rmode = 1; rand_dly = 0; cur_dly = 1; rty_w = -1; rty_n = 0; err_w = -1; abort_w = -1;
    start_xfer(25'h800, 10);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outs", {busy_o, done_o, err_o, cyc_o, stb_o, we_o, sel_o, adr_o, q_valid_o, q_dat_o}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
